cmd_fetch: RTL and testbench
============================

# cmd_fetch

Instruction fetch stage downstream of the command pointer (`cmd_point`). It takes the current pointer value (`addr_point`) when the pointer reports ready, and performs one read on the instruction memory bus using a req/ack handshake. The fetched word, tagged with its address, is presented to the decoder on a valid/accept handshake. It also supports flush on jumps and a sticky timeout error for a hung bus.

## Interface
Parameters:
- `BUS_WIDTH`, 32, address and data width
- `TIMEOUT`, 255, max cycles `mem_req` may stay high without `mem_ack` (≥2)
- `TO_WIDTH`, 8, timeout counter width; must hold `TIMEOUT`

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `addr_point`  in  BUS_WIDTH  pointer value from `cmd_point`
- `point_ready`  in  1  `cmd_point` ready; `addr_point` valid
- `flush`  in  1  discard in-flight/held fetch (decoder issued a jump)
- `mem_addr`  out  BUS_WIDTH  read address, stable while `mem_req`=1
- `mem_req`  out  1  read request
- `mem_ack`  in  1  one-cycle pulse; `mem_data` valid in that cycle
- `mem_data`  in  BUS_WIDTH  read data
- `instr`  out  BUS_WIDTH  fetched word
- `instr_addr`  out  BUS_WIDTH  address of `instr`
- `instr_valid`  out  1  `instr`/`instr_addr` valid
- `instr_accept`  in  1  decoder takes instr this cycle
- `timeout_err`  out  1  sticky bus timeout

## Operation
- States: IDLE, REQ, DROP, HOLD, ERR. Reset → IDLE.
- `armed` flag: set by reset, flush, or any cycle with `point_ready`=0. Cleared on launch. One fetch per pointer-ready episode.
- IDLE: if `point_ready` & `armed` & !`flush` then latch `addr_point` into `mem_addr`, clear timer, go to REQ.
- REQ: `mem_req`=1. On `mem_ack`, capture `mem_data`→`instr` and `mem_addr`→`instr_addr`, then go to HOLD. On `flush` without ack, go to DROP; `mem_req` cannot drop before ack. On `flush` with ack in the same cycle, discard data and go to IDLE.
- DROP: `mem_req`=1. On `mem_ack`, discard data and go to IDLE.
- HOLD: `instr_valid`=1; `instr`/`instr_addr` held stable. On `instr_accept` or `flush` (or both), go to IDLE.
- Timer: increments each REQ/DROP cycle without ack. After `TIMEOUT` cycles of `mem_req` without ack, go to ERR. Ack in the final cycle wins.
- ERR: `mem_req`=0, `instr_valid`=0, `timeout_err`=1. Only reset exits ERR.
- `mem_ack` outside REQ/DROP is ignored.
- Reset mid-transaction: `mem_req` drops next edge. The bus slave must tolerate this.
- Reset values: `mem_addr`=0, `mem_req`=0, `instr`=0, `instr_addr`=0, `instr_valid`=0, `timeout_err`=0.

## Timing
- Launch decided at edge N → `mem_req`=1 and `mem_addr` valid from cycle N+1.
- `mem_ack` in cycle M → `instr_valid`=1 and `mem_req`=0 in M+1.
- Zero-wait bus: `point_ready` sampled at N → `instr_valid` at N+2.
- `instr_accept` at K → `instr_valid`=0 at K+1. Earliest next launch is at K+1 if `armed`.
- `flush` at K → `instr_valid`=0 at K+1. No launch in cycle K.
- Throughput: at most one instruction per 3 cycles. No prefetch.
- All outputs are registered.

## Structure
- Shared package `cmd_pkg` holds:
  - opcode constants NUL/JMP/SJF/SJB (3'b000/001/010/100)
  - fetch state encoding
  - default `BUS_WIDTH`
- Sub-module `cmd_fetch_timer`: clear/enable counter with `expired` output at `TIMEOUT`. Everything else is flat in `cmd_fetch`.

## Test plan
- Basic fetch:
  - Stimulus: reset, `point_ready`=1, `addr_point`=0x1234; slave acks 0xDEADBEEF at 2nd req cycle.
  - Response: `mem_addr`=0x1234; `instr`=0xDEADBEEF, `instr_addr`=0x1234, valid 1 cycle after ack; one request only while `point_ready` stays high.
- Backpressure:
  - Stimulus: `instr_accept` held low 10 cycles, then pulsed.
  - Response: `instr_valid` high and `instr` stable for all 10 cycles; valid low the cycle after accept.
- Re-arm:
  - Stimulus: `point_ready` 1→0→1 with `addr_point` 0x1234→0x1236.
  - Response: exactly two fetches, at addresses 0x1234 and 0x1236.
- Flush during REQ:
  - Stimulus: flush 1 cycle before ack of 0x0002.
  - Response: `mem_req` held until ack; no `instr_valid`; next fetch at new `addr_point` 0x1238.
- Timeout:
  - Stimulus: `TIMEOUT`=4, never ack.
  - Response: `mem_req` high 4 cycles, then 0; `timeout_err`=1 sticky until reset; ack in 4th cycle instead yields normal HOLD.
- Reset mid-HOLD:
  - Stimulus: assert reset while `instr_valid`=1.
  - Response: all outputs zero next edge; fresh fetch after reset.

Source files
------------

// File: rtl/cmd_pkg.sv
// cmd_pkg: opcodes, fetch state encoding and default widths shared by the command pipeline
package cmd_pkg;
  localparam int DEF_BUS_WIDTH = 32;
  localparam logic [2:0] NUL = 3'b000;
  localparam logic [2:0] JMP = 3'b001;
  localparam logic [2:0] SJF = 3'b010;
  localparam logic [2:0] SJB = 3'b100;
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_DROP, S_HOLD, S_ERR} fetch_state_t;
endpackage

// File: rtl/cmd_fetch_timer.sv
// cmd_fetch_timer: clear/enable counter flagging the TIMEOUT-th enabled cycle
module cmd_fetch_timer #(
  parameter int TIMEOUT = 255,
  parameter int TO_WIDTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic expired
);
  logic [TO_WIDTH-1:0] cnt;
  assign expired = en && cnt == TO_WIDTH'(TIMEOUT - 1);
  always_ff @(posedge clk)
    if (reset || clear) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
endmodule

// File: rtl/cmd_fetch.sv
// cmd_fetch: fetches one instruction per pointer-ready episode over a req/ack bus
module cmd_fetch import cmd_pkg::*; #(
  parameter int BUS_WIDTH = DEF_BUS_WIDTH,
  parameter int TIMEOUT = 255,
  parameter int TO_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BUS_WIDTH-1:0] addr_point,
  input  logic                 point_ready,
  input  logic                 flush,
  output logic [BUS_WIDTH-1:0] mem_addr,
  output logic                 mem_req,
  input  logic                 mem_ack,
  input  logic [BUS_WIDTH-1:0] mem_data,
  output logic [BUS_WIDTH-1:0] instr,
  output logic [BUS_WIDTH-1:0] instr_addr,
  output logic                 instr_valid,
  input  logic                 instr_accept,
  output logic                 timeout_err
);
  fetch_state_t state, next;
  logic armed, launch, busy, expired;
  assign busy = state == S_REQ || state == S_DROP;
  assign launch = state == S_IDLE && point_ready && armed && !flush;
  cmd_fetch_timer #(.TIMEOUT(TIMEOUT), .TO_WIDTH(TO_WIDTH)) u_timer (
    .clk(clk), .reset(reset), .clear(launch), .en(busy && !mem_ack), .expired(expired)
  );
  // an ack in the final allowed cycle beats the timeout
  always_comb begin
    next = state;
    case (state)
      S_IDLE: next = launch ? S_REQ : S_IDLE;
      S_REQ:  next = mem_ack ? (flush ? S_IDLE : S_HOLD) : expired ? S_ERR : flush ? S_DROP : S_REQ;
      S_DROP: next = mem_ack ? S_IDLE : expired ? S_ERR : S_DROP;
      S_HOLD: next = (instr_accept || flush) ? S_IDLE : S_HOLD;
      S_ERR:  next = S_ERR;
      default: next = S_IDLE;
    endcase
  end
  // outputs are registered from the next state so they change exactly with it
  always_ff @(posedge clk)
    if (reset) begin
      state       <= S_IDLE;
      armed       <= 1'b1;
      mem_addr    <= '0;
      mem_req     <= 1'b0;
      instr       <= '0;
      instr_addr  <= '0;
      instr_valid <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= next;
      armed       <= launch ? 1'b0 : (armed || flush || !point_ready);
      mem_req     <= next == S_REQ || next == S_DROP;
      instr_valid <= next == S_HOLD;
      timeout_err <= next == S_ERR;
      if (launch) mem_addr <= addr_point;
      if (state == S_REQ && mem_ack && !flush) begin
        instr      <= mem_data;
        instr_addr <= mem_addr;
      end
    end
endmodule

// File: tb/tb_cmd_fetch.sv
// tb_cmd_fetch: directed per-feature tests of cmd_fetch with TIMEOUT=4
module tb_cmd_fetch;
  logic        clk = 0;
  logic        reset, point_ready, flush, mem_ack, instr_accept;
  logic [31:0] addr_point, mem_data, mem_addr, instr, instr_addr;
  logic        mem_req, instr_valid, timeout_err;
  int          checks = 0, errors = 0, starts = 0;
  logic        req_q = 0;

  cmd_fetch #(.BUS_WIDTH(32), .TIMEOUT(4), .TO_WIDTH(3)) dut (
    .clk(clk), .reset(reset), .addr_point(addr_point), .point_ready(point_ready),
    .flush(flush), .mem_addr(mem_addr), .mem_req(mem_req), .mem_ack(mem_ack),
    .mem_data(mem_data), .instr(instr), .instr_addr(instr_addr),
    .instr_valid(instr_valid), .instr_accept(instr_accept), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_req && !req_q) starts <= starts + 1;
    req_q <= mem_req;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1; point_ready = 0; flush = 0; mem_ack = 0; instr_accept = 0;
    addr_point = 0; mem_data = 0;
    tick(); tick();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", mem_req); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", timeout_err); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", mem_addr); end
    checks++; if (instr !== 32'h0 || instr_addr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h/%h want 0/0", instr, instr_addr); end
    reset = 0;
  endtask

  task automatic test_basic;
    int s0 = starts;
    point_ready = 1; addr_point = 32'h1234;
    tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h1234) begin errors++; $display("FAIL basic_req1: got %b/%h want 1/00001234", mem_req, mem_addr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL basic_nvalid: got %b want 0", instr_valid); end
    tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h1234) begin errors++; $display("FAIL basic_req2: got %b/%h want 1/00001234", mem_req, mem_addr); end
    mem_ack = 1; mem_data = 32'hDEADBEEF;
    tick();
    mem_ack = 0; mem_data = 32'h0;
    checks++; if (instr_valid !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL basic_valid: got valid %b req %b want 1/0", instr_valid, mem_req); end
    checks++; if (instr !== 32'hDEADBEEF || instr_addr !== 32'h1234) begin errors++; $display("FAIL basic_data: got %h@%h want deadbeef@00001234", instr, instr_addr); end
    checks++; if (starts - s0 !== 1) begin errors++; $display("FAIL basic_starts: got %0d want 1", starts - s0); end
  endtask

  task automatic test_backpressure;
    int s0 = starts;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (instr_valid !== 1'b1 || instr !== 32'hDEADBEEF) begin errors++; $display("FAIL bp_hold%0d: got %b/%h want 1/deadbeef", i, instr_valid, instr); end
    end
    instr_accept = 1;
    tick();
    instr_accept = 0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got %b want 0", instr_valid); end
    for (int i = 0; i < 5; i++) tick();
    checks++; if (mem_req !== 1'b0 || starts !== s0) begin errors++; $display("FAIL bp_no_refetch: got req %b starts %0d want 0/%0d", mem_req, starts, s0); end
  endtask

  task automatic test_rearm;
    int s0 = starts;
    point_ready = 0; tick();
    point_ready = 1; addr_point = 32'h1234; tick();
    checks++; if (mem_addr !== 32'h1234) begin errors++; $display("FAIL rearm_addr1: got %h want 00001234", mem_addr); end
    mem_ack = 1; mem_data = 32'hA1; tick(); mem_ack = 0;
    checks++; if (instr_addr !== 32'h1234 || instr !== 32'hA1) begin errors++; $display("FAIL rearm_instr1: got %h@%h want a1@00001234", instr, instr_addr); end
    instr_accept = 1; tick(); instr_accept = 0;
    point_ready = 0; tick();
    point_ready = 1; addr_point = 32'h1236; tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h1236) begin errors++; $display("FAIL rearm_addr2: got %b/%h want 1/00001236", mem_req, mem_addr); end
    mem_ack = 1; mem_data = 32'hA2; tick(); mem_ack = 0;
    checks++; if (instr_addr !== 32'h1236 || instr !== 32'hA2) begin errors++; $display("FAIL rearm_instr2: got %h@%h want a2@00001236", instr, instr_addr); end
    instr_accept = 1; tick(); instr_accept = 0;
    tick(); tick();
    checks++; if (starts - s0 !== 2) begin errors++; $display("FAIL rearm_count: got %0d want 2", starts - s0); end
  endtask

  task automatic test_flush_req;
    point_ready = 0; tick();
    point_ready = 1; addr_point = 32'h0002; tick();
    tick();
    flush = 1; tick(); flush = 0;
    addr_point = 32'h1238;
    checks++; if (mem_req !== 1'b1 || instr_valid !== 1'b0) begin errors++; $display("FAIL flush_drop: got req %b valid %b want 1/0", mem_req, instr_valid); end
    mem_ack = 1; mem_data = 32'hBAD; tick(); mem_ack = 0;
    checks++; if (mem_req !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL flush_discard: got req %b valid %b want 0/0", mem_req, instr_valid); end
    tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h1238) begin errors++; $display("FAIL flush_next: got %b/%h want 1/00001238", mem_req, mem_addr); end
    mem_ack = 1; mem_data = 32'hC0DE; tick(); mem_ack = 0;
    checks++; if (instr_valid !== 1'b1 || instr !== 32'hC0DE || instr_addr !== 32'h1238) begin errors++; $display("FAIL flush_fetch: got %b %h@%h want 1 c0de@00001238", instr_valid, instr, instr_addr); end
    flush = 1; tick(); flush = 0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL flush_hold: got %b want 0", instr_valid); end
  endtask

  task automatic test_timeout;
    point_ready = 0; tick();
    point_ready = 1; addr_point = 32'h40; tick();
    for (int i = 0; i < 3; i++) tick();
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL to_late_req: got %b want 1", mem_req); end
    mem_ack = 1; mem_data = 32'h55; tick(); mem_ack = 0;
    checks++; if (instr_valid !== 1'b1 || timeout_err !== 1'b0 || instr !== 32'h55) begin errors++; $display("FAIL to_late_ack: got valid %b err %b instr %h want 1/0/55", instr_valid, timeout_err, instr); end
    instr_accept = 1; tick(); instr_accept = 0;
    point_ready = 0; tick();
    point_ready = 1; addr_point = 32'h80; tick();
    for (int i = 0; i < 4; i++) begin
      checks++; if (mem_req !== 1'b1 || timeout_err !== 1'b0) begin errors++; $display("FAIL to_req%0d: got req %b err %b want 1/0", i, mem_req, timeout_err); end
      tick();
    end
    checks++; if (mem_req !== 1'b0 || timeout_err !== 1'b1) begin errors++; $display("FAIL to_err: got req %b err %b want 0/1", mem_req, timeout_err); end
    mem_ack = 1; flush = 1; point_ready = 0; tick();
    mem_ack = 0; flush = 0; point_ready = 1; tick(); tick();
    checks++; if (timeout_err !== 1'b1 || mem_req !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL to_sticky: got err %b req %b valid %b want 1/0/0", timeout_err, mem_req, instr_valid); end
    point_ready = 0; reset = 1; tick(); reset = 0;
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_clear: got %b want 0", timeout_err); end
  endtask

  task automatic test_reset_hold;
    point_ready = 1; addr_point = 32'h99; tick();
    mem_ack = 1; mem_data = 32'hAB; tick(); mem_ack = 0;
    checks++; if (instr_valid !== 1'b1 || instr !== 32'hAB) begin errors++; $display("FAIL rh_hold: got %b/%h want 1/ab", instr_valid, instr); end
    reset = 1; tick(); reset = 0;
    checks++; if ({mem_req, instr_valid, timeout_err} !== 3'b000 || mem_addr !== 0 || instr !== 0 || instr_addr !== 0) begin errors++; $display("FAIL rh_zero: got req %b valid %b err %b addr %h instr %h@%h want all 0", mem_req, instr_valid, timeout_err, mem_addr, instr, instr_addr); end
    tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h99) begin errors++; $display("FAIL rh_refetch: got %b/%h want 1/00000099", mem_req, mem_addr); end
    mem_ack = 1; mem_data = 32'hAB2; tick(); mem_ack = 0;
    checks++; if (instr_valid !== 1'b1 || instr !== 32'hAB2 || instr_addr !== 32'h99) begin errors++; $display("FAIL rh_fetch: got %b %h@%h want 1 ab2@00000099", instr_valid, instr, instr_addr); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_rearm();
    test_flush_req();
    test_timeout();
    test_reset_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
